// File: rtl/llki_discrete_initiator_if.sv
// LLKI discrete initiator bundle: command/response, key RAM read port and
// the discrete key-load interface towards the mock-TSS receiver.
interface llki_discrete_initiator_if #(
  parameter int unsigned ADDR_W = 8
);

  // Command from the LLKI protocol processor
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_num_words;

  // Synchronous key RAM read port
  logic              key_rd_en;
  logic [ADDR_W-1:0] key_rd_addr;
  logic [63:0]       key_rd_data;

  // Discrete key-load interface
  logic [63:0]       llkid_key_data;
  logic              llkid_key_valid;
  logic              llkid_key_ready;
  logic              llkid_key_complete;
  logic              llkid_clear_key;
  logic              llkid_clear_key_ack;

  // Per-command status response
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [7:0]        rsp_words_sent;

  // Initiator side (the design)
  modport master (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_num_words,
    input  key_rd_data,
    input  llkid_key_ready,
    input  llkid_key_complete,
    input  llkid_clear_key_ack,
    output cmd_ready,
    output key_rd_en,
    output key_rd_addr,
    output llkid_key_data,
    output llkid_key_valid,
    output llkid_clear_key,
    output rsp_valid,
    output rsp_status,
    output rsp_words_sent
  );

  // Environment side: processor, key RAM and receiver
  modport slave (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_num_words,
    output key_rd_data,
    output llkid_key_ready,
    output llkid_key_complete,
    output llkid_clear_key_ack,
    input  cmd_ready,
    input  key_rd_en,
    input  key_rd_addr,
    input  llkid_key_data,
    input  llkid_key_valid,
    input  llkid_clear_key,
    input  rsp_valid,
    input  rsp_status,
    input  rsp_words_sent
  );

endinterface

// File: rtl/llki_discrete_initiator.sv
// LLKI discrete initiator: executes load-key / clear-key commands against a
// mock-TSS key-load port. Load streams words fetched from a synchronous key
// RAM (one fetch, one capture, one send state per word) and then waits for
// the receiver's complete flag. Every handshake wait is bounded by
// TIMEOUT_CYCLES. Exactly one response is produced per accepted command.
module llki_discrete_initiator #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                       clk,
  input logic                       rst,
  llki_discrete_initiator_if.master bus_io
);

  // FSM encoding
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StLoad    = 3'd2;
  localparam logic [2:0] StSend    = 3'd3;
  localparam logic [2:0] StWaitCpl = 3'd4;
  localparam logic [2:0] StClear   = 3'd5;
  localparam logic [2:0] StResp    = 3'd6;

  // Command opcodes
  localparam logic [1:0] OpLoad  = 2'd1;
  localparam logic [1:0] OpClear = 2'd2;

  // Response status codes
  localparam logic [1:0] StatOk      = 2'd0;
  localparam logic [1:0] StatTimeout = 2'd1;
  localparam logic [1:0] StatBadLen  = 2'd2;
  localparam logic [1:0] StatBadOp   = 2'd3;

  // The wait counter only has to reach TIMEOUT_CYCLES-1: the cycle holding
  // that value is the last waiting cycle allowed.
  localparam int unsigned       WaitW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        num_q, num_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [1:0]        stat_q, stat_d;
  logic [63:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              clear_q, clear_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [7:0]        rsp_words_q, rsp_words_d;

  logic              op_legal;
  logic              wait_expired;
  logic [7:0]        cnt_inc;

  assign op_legal     = (bus_io.cmd_op == OpLoad) || (bus_io.cmd_op == OpClear);
  assign wait_expired = (wait_q == WaitLast);
  assign cnt_inc      = cnt_q + 8'd1;

  // Next-state logic for the command sequencer and all registered outputs
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    wait_d       = '0;
    stat_d       = stat_q;
    data_d       = data_q;
    valid_d      = valid_q;
    clear_d      = clear_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_words_d  = rsp_words_q;

    case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          base_d = bus_io.cmd_addr;
          num_d  = bus_io.cmd_num_words;
          cnt_d  = '0;
          if (!op_legal) begin
            stat_d  = StatBadOp;
            state_d = StResp;
          end else if (bus_io.cmd_op == OpLoad) begin
            if (bus_io.cmd_num_words == 8'd0) begin
              stat_d  = StatBadLen;
              state_d = StResp;
            end else begin
              state_d = StFetch;
            end
          end else begin
            clear_d = 1'b1;
            state_d = StClear;
          end
        end
      end

      // Read address is driven combinationally in this state
      StFetch: begin
        if (bus_io.llkid_key_complete) begin
          stat_d  = StatBadLen;
          state_d = StResp;
        end else begin
          state_d = StLoad;
        end
      end

      // RAM data is valid now; capture it into the output word
      StLoad: begin
        if (bus_io.llkid_key_complete) begin
          stat_d  = StatBadLen;
          state_d = StResp;
        end else begin
          data_d  = bus_io.key_rd_data;
          valid_d = 1'b1;
          state_d = StSend;
        end
      end

      StSend: begin
        if (bus_io.llkid_key_ready) begin
          cnt_d   = cnt_inc;
          valid_d = 1'b0;
          if (cnt_inc == num_q) begin
            // Complete together with the last word is a clean finish
            if (bus_io.llkid_key_complete) begin
              stat_d  = StatOk;
              state_d = StResp;
            end else begin
              state_d = StWaitCpl;
            end
          end else if (bus_io.llkid_key_complete) begin
            stat_d  = StatBadLen;
            state_d = StResp;
          end else begin
            state_d = StFetch;
          end
        end else if (bus_io.llkid_key_complete) begin
          valid_d = 1'b0;
          stat_d  = StatBadLen;
          state_d = StResp;
        end else if (wait_expired) begin
          valid_d = 1'b0;
          stat_d  = StatTimeout;
          state_d = StResp;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      StWaitCpl: begin
        if (bus_io.llkid_key_complete) begin
          stat_d  = StatOk;
          state_d = StResp;
        end else if (wait_expired) begin
          stat_d  = StatTimeout;
          state_d = StResp;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      // cnt_q stays zero for a clear, so words_sent reports 0
      StClear: begin
        if (bus_io.llkid_clear_key_ack) begin
          clear_d = 1'b0;
          stat_d  = StatOk;
          state_d = StResp;
        end else if (wait_expired) begin
          clear_d = 1'b0;
          stat_d  = StatTimeout;
          state_d = StResp;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      StResp: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = stat_q;
        rsp_words_d  = cnt_q;
        state_d      = StIdle;
      end

      default: begin
        valid_d = 1'b0;
        clear_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops valid/clear with no response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
      stat_q       <= StatOk;
      data_q       <= '0;
      valid_q      <= 1'b0;
      clear_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= StatOk;
      rsp_words_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      stat_q       <= stat_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      clear_q      <= clear_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_words_q  <= rsp_words_d;
    end
  end

  // Output decode; the read address wraps modulo 2^ADDR_W
  always_comb begin
    bus_io.cmd_ready       = (state_q == StIdle);
    bus_io.key_rd_en       = (state_q == StFetch);
    bus_io.key_rd_addr     = (state_q == StFetch) ? base_q + ADDR_W'(cnt_q) : '0;
    bus_io.llkid_key_data  = data_q;
    bus_io.llkid_key_valid = valid_q;
    bus_io.llkid_clear_key = clear_q;
    bus_io.rsp_valid       = rsp_valid_q;
    bus_io.rsp_status      = rsp_status_q;
    bus_io.rsp_words_sent  = rsp_words_q;
  end

endmodule

// File: tb/tb_llki_discrete_initiator.sv
// Scoreboard bench for llki_discrete_initiator: directed commands push the
// expected RAM addresses, transferred words and responses into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_llki_discrete_initiator;

  logic clk;
  logic rst;

  llki_discrete_initiator_if #(.ADDR_W(8)) bus ();

  llki_discrete_initiator #(
    .ADDR_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [7:0] w;
    int         lat;
  } rsp_t;

  logic [7:0]  qa[$];
  logic [63:0] qd[$];
  rsp_t        qr[$];
  rsp_t        mon_e;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int rsp_seen = 0;

  // Receiver configuration
  bit rx_ready_en;
  int rx_stall;
  bit rx_cpl_last;
  int rx_words;
  int rx_cpl_after;
  int rx_cpl_delay;
  bit rx_ack_en;
  int rx_ack_delay;

  int seen = 0;
  int since = 0;
  int stall_cnt = 0;
  int clr_cnt = 0;
  int clr_high = 0;

  function automatic logic [63:0] kw(input logic [7:0] a);
    return {a, 8'h5A, ~a, 8'hC3, a ^ 8'h3C, 24'h123456};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous key RAM
  always @(posedge clk) begin
    if (bus.key_rd_en) bus.key_rd_data <= kw(bus.key_rd_addr);
  end

  // Receiver bookkeeping, restarted at each command acceptance
  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      seen <= 0; since <= 0; stall_cnt <= 0; clr_cnt <= 0; clr_high <= 0;
    end else begin
      if (bus.llkid_key_valid && bus.llkid_key_ready) begin
        seen      <= seen + 1;
        stall_cnt <= 0;
        if (seen + 1 == rx_cpl_after) since <= 1;
        else if (since > 0) since <= since + 1;
      end else begin
        stall_cnt <= bus.llkid_key_valid ? stall_cnt + 1 : 0;
        if (since > 0) since <= since + 1;
      end
      if (bus.llkid_clear_key) begin
        clr_cnt  <= clr_cnt + 1;
        clr_high <= clr_high + 1;
      end
    end
  end

  assign bus.llkid_key_ready = rx_ready_en &&
      (rx_stall == 0 || (bus.llkid_key_valid && stall_cnt >= rx_stall));
  assign bus.llkid_key_complete = (since != 0 && since == rx_cpl_delay) ||
      (rx_cpl_last && bus.llkid_key_valid && bus.llkid_key_ready && seen == rx_words - 1);
  assign bus.llkid_clear_key_ack = rx_ack_en && bus.llkid_clear_key && clr_cnt >= rx_ack_delay;

  // Monitor: compare everything the DUT presents against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_rd_en) begin
        if (qa.size() == 0) begin
          n_total++;
          $display("FAIL rd_addr: unexpected read of %0h, none expected", bus.key_rd_addr);
        end else chk("rd_addr", 64'(bus.key_rd_addr), 64'(qa.pop_front()));
      end
      if (bus.llkid_key_valid && bus.llkid_key_ready) begin
        if (qd.size() == 0) begin
          n_total++;
          $display("FAIL key_xfer: unexpected word %0h, none expected", bus.llkid_key_data);
        end else chk("key_data", bus.llkid_key_data, qd.pop_front());
      end else if (bus.llkid_key_valid && qd.size() != 0) begin
        chk("key_data_hold", bus.llkid_key_data, qd[0]);
      end
      if (bus.llkid_key_valid && bus.llkid_clear_key) begin
        n_total++;
        $display("FAIL valid_clear_excl: both high, required never both");
      end
      if (bus.rsp_valid) begin
        rsp_seen++;
        if (qr.size() == 0) begin
          n_total++;
          $display("FAIL rsp: unexpected status %0d words %0d, none expected",
                   bus.rsp_status, bus.rsp_words_sent);
        end else begin
          mon_e = qr.pop_front();
          chk("rsp_status", 64'(bus.rsp_status), 64'(mon_e.st));
          chk("rsp_words", 64'(bus.rsp_words_sent), 64'(mon_e.w));
          if (mon_e.lat >= 0) chk("rsp_latency", 64'(cyc - accept_cyc), 64'(mon_e.lat));
        end
      end
    end
  end

  task automatic cfg_rx(input bit ready_en, input int stall, input bit cpl_last,
                        input int words, input int cpl_after, input int cpl_delay,
                        input bit ack_en, input int ack_delay);
    rx_ready_en = ready_en; rx_stall = stall; rx_cpl_last = cpl_last; rx_words = words;
    rx_cpl_after = cpl_after; rx_cpl_delay = cpl_delay;
    rx_ack_en = ack_en; rx_ack_delay = ack_delay;
  endtask

  task automatic exp_load(input logic [7:0] base, input int nfetch, input int nxfer);
    for (int i = 0; i < nfetch; i++) qa.push_back(base + 8'(i));
    for (int i = 0; i < nxfer; i++) qd.push_back(kw(base + 8'(i)));
  endtask

  task automatic exp_rsp(input logic [1:0] st, input logic [7:0] w, input int lat);
    rsp_t e;
    e.st = st; e.w = w; e.lat = lat;
    qr.push_back(e);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] n);
    bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_num_words = n;
    bus.cmd_valid = 1'b1;
    tick();
    accept_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int budget);
    int start;
    int n;
    start = rsp_seen;
    n = 0;
    while (rsp_seen == start && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_rsp_arrived"}, 64'(rsp_seen != start), 64'd1);
    tick();
    tick();
    chk({name, "_scoreboard_drained"}, 64'(qa.size() + qd.size() + qr.size()), 64'd0);
    qa.delete(); qd.delete(); qr.delete();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = 8'd0; bus.cmd_num_words = 8'd0;
    cfg_rx(1'b1, 0, 1'b0, 0, 0, 0, 1'b0, 0);
    rst = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("reset_valid", 64'(bus.llkid_key_valid), 64'd0);
    chk("reset_clear", 64'(bus.llkid_clear_key), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rd_en", 64'(bus.key_rd_en), 64'd0);
    chk("reset_rsp_status", 64'(bus.rsp_status), 64'd0);
    chk("reset_key_data", bus.llkid_key_data, 64'd0);
    rst = 1'b0;
    tick();

    // 4-word load, ready tied high, complete with last word: 3N+1 latency
    cfg_rx(1'b1, 0, 1'b1, 4, 0, 0, 1'b0, 0);
    exp_load(8'h10, 4, 4); exp_rsp(2'd0, 8'd4, 13);
    send_cmd(2'd1, 8'h10, 8'd4);
    wait_rsp("load4", 60);
    chk("rsp_status_hold", 64'(bus.rsp_status), 64'd0);
    chk("rsp_words_hold", 64'(bus.rsp_words_sent), 64'd4);

    // 2-word load, 5-cycle stall per word, complete 3 cycles after last word
    cfg_rx(1'b1, 5, 1'b0, 2, 2, 3, 1'b0, 0);
    exp_load(8'h20, 2, 2); exp_rsp(2'd0, 8'd2, 20);
    send_cmd(2'd1, 8'h20, 8'd2);
    wait_rsp("load2_stall", 60);

    // Ready never asserted: timeout after 16 waiting cycles, no words
    cfg_rx(1'b0, 0, 1'b0, 3, 0, 0, 1'b0, 0);
    exp_load(8'h30, 1, 0); exp_rsp(2'd1, 8'd0, 19);
    send_cmd(2'd1, 8'h30, 8'd3);
    wait_rsp("timeout_ready", 60);

    // All words sent, complete never arrives
    cfg_rx(1'b1, 0, 1'b0, 3, 0, 0, 1'b0, 0);
    exp_load(8'h40, 3, 3); exp_rsp(2'd1, 8'd3, 26);
    send_cmd(2'd1, 8'h40, 8'd3);
    wait_rsp("timeout_cpl", 60);

    // Early complete right after the 2nd of 4 words
    cfg_rx(1'b1, 0, 1'b0, 4, 2, 1, 1'b0, 0);
    exp_load(8'h50, 3, 2); exp_rsp(2'd2, 8'd2, 8);
    send_cmd(2'd1, 8'h50, 8'd4);
    wait_rsp("early_cpl", 60);

    // Zero-length load and illegal opcodes: response only, no interface activity
    cfg_rx(1'b1, 0, 1'b0, 0, 0, 0, 1'b1, 0);
    exp_rsp(2'd2, 8'd0, 1);
    send_cmd(2'd1, 8'h70, 8'd0);
    wait_rsp("bad_len", 20);
    exp_rsp(2'd3, 8'd0, 1);
    send_cmd(2'd3, 8'h70, 8'd4);
    wait_rsp("bad_op3", 20);
    exp_rsp(2'd3, 8'd0, 1);
    send_cmd(2'd0, 8'h70, 8'd4);
    wait_rsp("bad_op0", 20);

    // Clear acknowledged in the 8th cycle of the request
    cfg_rx(1'b1, 0, 1'b0, 0, 0, 0, 1'b1, 7);
    exp_rsp(2'd0, 8'd0, 9);
    send_cmd(2'd2, 8'h00, 8'd0);
    wait_rsp("clear_ack", 40);
    chk("clear_high_cycles", 64'(clr_high), 64'd8);

    // Clear never acknowledged
    cfg_rx(1'b1, 0, 1'b0, 0, 0, 0, 1'b0, 0);
    exp_rsp(2'd1, 8'd0, 17);
    send_cmd(2'd2, 8'h00, 8'd0);
    wait_rsp("clear_timeout", 40);
    chk("clear_timeout_high_cycles", 64'(clr_high), 64'd16);

    // Reset while word 2 of 4 is being offered
    begin
      int n;
      cfg_rx(1'b1, 3, 1'b0, 4, 0, 0, 1'b0, 0);
      exp_load(8'h60, 2, 1);
      send_cmd(2'd1, 8'h60, 8'd4);
      n = 0;
      while (!(seen == 1 && bus.llkid_key_valid) && n < 40) begin
        tick();
        n++;
      end
      chk("rst_reached_word2", 64'(seen == 1 && bus.llkid_key_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid_low", 64'(bus.llkid_key_valid), 64'd0);
      chk("rst_clear_low", 64'(bus.llkid_clear_key), 64'd0);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("rst_no_rsp_drained", 64'(qa.size() + qd.size() + qr.size()), 64'd0);
      qa.delete(); qd.delete(); qr.delete();
    end

    cfg_rx(1'b1, 0, 1'b1, 4, 0, 0, 1'b0, 0);
    exp_load(8'h60, 4, 4); exp_rsp(2'd0, 8'd4, 13);
    send_cmd(2'd1, 8'h60, 8'd4);
    wait_rsp("after_rst_load", 60);

    // Address wrap FE, FF, 00
    cfg_rx(1'b1, 0, 1'b1, 3, 0, 0, 1'b0, 0);
    exp_load(8'hFE, 3, 3); exp_rsp(2'd0, 8'd3, 10);
    send_cmd(2'd1, 8'hFE, 8'd3);
    wait_rsp("wrap", 60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
